// File: rtl/ltc2174_pkg.sv
// Shared constants for the LTC2174 serial-port responder: register map,
// field bit positions and the frame FSM state encoding.
`timescale 1ns/1ps
package ltc2174_pkg;

  localparam logic [6:0] ADDR_RESET   = 7'd0;
  localparam logic [6:0] ADDR_FORMAT  = 7'd1;
  localparam logic [6:0] ADDR_OUTMODE = 7'd2;
  localparam logic [6:0] ADDR_TESTMSB = 7'd3;
  localparam logic [6:0] ADDR_TESTLSB = 7'd4;

  localparam logic [7:0] REG_RST_VAL = 8'h00;

  localparam int BIT_SWRESET  = 7;
  localparam int BIT_DSCOFF   = 7;
  localparam int BIT_RAND     = 6;
  localparam int BIT_TWOSCOMP = 5;
  localparam int BIT_TERMON   = 4;
  localparam int BIT_OUTOFF   = 3;
  localparam int BIT_OUTTEST  = 7;
  localparam int BIT_A3_RSVD  = 6;

  localparam logic [7:0] A3_WR_MASK = ~(8'h01 << BIT_A3_RSVD);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_e;

endpackage

// File: rtl/ltc2174_spi_slave_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_dly;
  assign o_fall  = ~o_level & r_dly;

endmodule

// File: rtl/ltc2174_spi_slave.sv
// LTC2174 4-wire serial programming port responder: oversampled SPI frame
// decoder, register file A0..A4, mode-field outputs and read-back on SDO.
`timescale 1ns/1ps
module ltc2174_spi_slave
  import ltc2174_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_MAX    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic        dscoff,
  output logic        randomizer,
  output logic        twoscomp,
  output logic [4:0]  sleep,
  output logic [2:0]  ilvds,
  output logic        termon,
  output logic        outoff,
  output logic [2:0]  outmode,
  output logic        outtest,
  output logic [13:0] testpattern,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic        frame_abort
);

  localparam logic [6:0] ADDR_TOP = (ADDR_MAX < 4) ? 7'(ADDR_MAX) : ADDR_TESTLSB;

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sck_lvl_unused, w_sck_rise, w_sck_fall;
  logic w_sdi, w_sdi_rise_unused, w_sdi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset_n(reset_n), .i_pin(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset_n(reset_n), .i_pin(sck),
    .o_level(w_sck_lvl_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(clk), .reset_n(reset_n), .i_pin(sdi),
    .o_level(w_sdi), .o_rise(w_sdi_rise_unused), .o_fall(w_sdi_fall_unused));

  spi_state_e        r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  logic [15:0]       r_shift;
  logic [15:0]       w_frame;
  logic              r_rw;
  logic [7:0]        r_out, w_rd_data;
  logic [7:0]        r_a1, r_a2, r_a3, r_a4;
  logic [7:0]        r_f1, r_f2, r_f4;
  logic [6:0]        r_f3;
  logic [SYNC_STAGES:0] r_settle;
  logic              r_armed;
  logic w_start, w_abort, w_shift, w_cmd_done, w_last, w_sdo_shift;

  assign w_frame = {r_shift[14:0], w_sdi};

  // After reset the synchronizers hold reset values; a cs fall is only trusted
  // once cs has been seen high with live data, so a frame in flight is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
      r_armed  <= r_armed | (r_settle[SYNC_STAGES] & w_cs_lvl);
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_shift     = 1'b0;
    w_cmd_done  = 1'b0;
    w_last      = 1'b0;
    w_sdo_shift = 1'b0;
    case (r_state)
      IDLE: if (w_cs_fall && r_armed) begin
        w_start     = 1'b1;
        w_state_nxt = CMD;
      end
      CMD: if (w_cs_rise) begin
        w_abort     = 1'b1;
        w_state_nxt = IDLE;
      end else if (w_sck_rise) begin
        w_shift = 1'b1;
        if (r_cnt == 4'd7) begin
          w_cmd_done  = 1'b1;
          w_state_nxt = DATA;
        end
      end
      DATA: if (w_cs_rise) begin
        w_abort     = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        if (w_sck_rise) begin
          w_shift = 1'b1;
          if (r_cnt == 4'd15) begin
            w_last      = 1'b1;
            w_state_nxt = DONE;
          end
        end
        w_sdo_shift = w_sck_fall & r_rw;
      end
      DONE: if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // At the 8th rise w_frame[7:0] is the command byte {rw, addr}.
  always_comb begin
    w_rd_data = REG_RST_VAL;
    if (w_frame[6:0] <= ADDR_TOP) begin
      case (w_frame[6:0])
        ADDR_FORMAT:  w_rd_data = r_a1;
        ADDR_OUTMODE: w_rd_data = r_a2;
        ADDR_TESTMSB: w_rd_data = r_a3;
        ADDR_TESTLSB: w_rd_data = r_a4;
        default:      w_rd_data = REG_RST_VAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_out       <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      frame_abort <= 1'b0;
      r_a1 <= REG_RST_VAL;
      r_a2 <= REG_RST_VAL;
      r_a3 <= REG_RST_VAL;
      r_a4 <= REG_RST_VAL;
      r_f1 <= '0;
      r_f2 <= '0;
      r_f3 <= '0;
      r_f4 <= '0;
    end else begin
      wr_strobe   <= 1'b0;
      frame_abort <= w_abort;
      if (w_start) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_shift) begin
        r_cnt   <= r_cnt + 4'd1;
        r_shift <= w_frame;
      end
      if (w_cmd_done) begin
        r_rw <= w_frame[7];
        if (w_frame[7]) begin
          r_out  <= w_rd_data;
          sdo_oe <= 1'b1;
        end
      end
      if (w_sdo_shift) begin
        sdo   <= r_out[7];
        r_out <= {r_out[6:0], 1'b0};
      end
      if (w_cs_rise) begin
        sdo_oe <= 1'b0;
        sdo    <= 1'b0;
      end
      // w_frame on the 16th rise is {rw, addr[6:0], data[7:0]}.
      if (w_last && !w_frame[15] && (w_frame[14:8] <= ADDR_TOP)) begin
        case (w_frame[14:8])
          ADDR_RESET: if (w_frame[BIT_SWRESET]) begin
            r_a1      <= REG_RST_VAL;
            r_a2      <= REG_RST_VAL;
            r_a3      <= REG_RST_VAL;
            r_a4      <= REG_RST_VAL;
            wr_strobe <= 1'b1;
            wr_addr   <= ADDR_RESET;
          end
          ADDR_FORMAT:  r_a1 <= w_frame[7:0];
          ADDR_OUTMODE: r_a2 <= w_frame[7:0];
          ADDR_TESTMSB: r_a3 <= w_frame[7:0] & A3_WR_MASK;
          ADDR_TESTLSB: r_a4 <= w_frame[7:0];
          default: ;
        endcase
        if (w_frame[14:8] != ADDR_RESET) begin
          wr_strobe <= 1'b1;
          wr_addr   <= w_frame[14:8];
        end
      end
      r_f1 <= r_a1;
      r_f2 <= r_a2;
      r_f3 <= {r_a3[BIT_OUTTEST], r_a3[5:0]};
      r_f4 <= r_a4;
    end
  end

  assign dscoff      = r_f1[BIT_DSCOFF];
  assign randomizer  = r_f1[BIT_RAND];
  assign twoscomp    = r_f1[BIT_TWOSCOMP];
  assign sleep       = r_f1[4:0];
  assign ilvds       = r_f2[7:5];
  assign termon      = r_f2[BIT_TERMON];
  assign outoff      = r_f2[BIT_OUTOFF];
  assign outmode     = r_f2[2:0];
  assign outtest     = r_f3[6];
  assign testpattern = {r_f3[5:0], r_f4};

endmodule

// File: tb/tb_ltc2174_spi_slave.sv
// Bench for ltc2174_spi_slave: SPI frames driven on the pins, expected write
// and read responses queued from a register-map model and checked by monitors.
`timescale 1ns/1ps
module tb_ltc2174_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo, sdo_oe, dscoff, randomizer, twoscomp, termon, outoff, outtest;
  logic [4:0]  sleep;
  logic [2:0]  ilvds, outmode;
  logic [13:0] testpattern;
  logic        wr_strobe, frame_abort;
  logic [6:0]  wr_addr;

  ltc2174_spi_slave #(.SYNC_STAGES(2), .ADDR_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .sck(sck), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .dscoff(dscoff), .randomizer(randomizer),
    .twoscomp(twoscomp), .sleep(sleep), .ilvds(ilvds), .termon(termon),
    .outoff(outoff), .outmode(outmode), .outtest(outtest),
    .testpattern(testpattern), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_abort(frame_abort));

  always #5 clk = ~clk;

  wire [30:0] dut_fields = {dscoff, randomizer, twoscomp, sleep, ilvds, termon,
                            outoff, outmode, outtest, testpattern};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Register-map model: A0..A4 as bytes, fields taken straight from the map.
  logic [7:0] mdl [0:4];
  typedef struct {logic [6:0] addr; logic [30:0] fields;} wr_exp_t;
  wr_exp_t    exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  int  exp_abort = 0, act_abort = 0, act_strobes = 0;
  bit  cur_is_read = 1'b0;
  int  H = 16;

  function automatic logic [30:0] model_fields();
    return {mdl[1], mdl[2], mdl[3][7], mdl[3][5:0], mdl[4]};
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a);
    return (a >= 7'd1 && a <= 7'd4) ? mdl[a[2:0]] : 8'h00;
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    wr_exp_t e;
    if (a == 7'd0) begin
      if (d[7]) begin
        for (int i = 1; i <= 4; i++) mdl[i] = 8'h00;
        e.addr = 7'd0; e.fields = model_fields(); exp_wr_q.push_back(e);
      end
    end else if (a <= 7'd4) begin
      mdl[a[2:0]] = (a == 7'd3) ? (d & 8'hBF) : d;
      e.addr = a; e.fields = model_fields(); exp_wr_q.push_back(e);
    end
  endtask

  task automatic frame(input bit rw, input logic [6:0] a, input logic [7:0] d,
                       input int nrise, input int rst_at);
    logic [15:0] w;
    w = {rw, a, d};
    cur_is_read = rw;
    @(negedge clk) cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      sdi = w[15-i];
      repeat (H) @(negedge clk);
      sck = 1'b1;
      if (i + 1 == rst_at) begin
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_fields", dut_fields, 31'h0);
        chk("rst_mid_sdo_oe", sdo_oe, 1'b0);
        chk("rst_mid_sdo", sdo, 1'b0);
        chk("rst_mid_wr_addr", wr_addr, 7'h0);
        chk("rst_mid_wr_strobe", wr_strobe, 1'b0);
        chk("rst_mid_frame_abort", frame_abort, 1'b0);
        for (int j = 1; j <= 4; j++) mdl[j] = 8'h00;
        @(negedge clk) reset_n = 1'b1;
      end
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (H + 8) @(negedge clk);
    chk("sdo_oe_after_cs", sdo_oe, 1'b0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    model_write(a, d);
    frame(1'b0, a, d, 16, 0);
  endtask

  task automatic rd(input logic [6:0] a);
    exp_rd_q.push_back(model_read(a));
    frame(1'b1, a, 8'($urandom), 16, 0);
  endtask

  // Write monitor: every wr_strobe consumes one expected commit.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && frame_abort) act_abort++;
      if (wr_strobe) begin
        act_strobes++;
        if (exp_wr_q.size() == 0) chk("unexpected_wr_strobe", wr_addr, 7'h7F);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          @(negedge clk);
          chk("fields_after_commit", dut_fields, e.fields);
        end
      end
    end
  end

  // Read monitor: sample SDO at sck rises 9..16 of read frames.
  logic [7:0] rd_sh = 8'h00;
  int         k = 0;
  always @(negedge cs or posedge sck) begin
    if (!sck) k = 0;
    else begin
      k++;
      if (k == 8) chk("sdo_oe_cmd_phase", sdo_oe, 1'b0);
      if (cur_is_read && k > 8 && k <= 16) begin
        chk("sdo_oe_data_phase", sdo_oe, 1'b1);
        rd_sh = {rd_sh[6:0], sdo};
        if (k == 16) begin
          if (exp_rd_q.size() == 0) chk("unexpected_read", rd_sh, 9'h1FF);
          else chk("read_data", rd_sh, exp_rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i <= 4; i++) mdl[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_sdo", sdo, 1'b0);
    chk("reset_sdo_oe", sdo_oe, 1'b0);
    chk("reset_wr_strobe", wr_strobe, 1'b0);
    chk("reset_wr_addr", wr_addr, 7'h0);
    chk("reset_frame_abort", frame_abort, 1'b0);
    chk("reset_fields", dut_fields, 31'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    H = 16;
    wr(7'd1, 8'hA5); wr(7'd2, 8'h3B); wr(7'd3, 8'h92); wr(7'd4, 8'h7E);
    chk("strobe_count_4", act_strobes, 4);
    chk("dscoff", dscoff, 1'b1);
    chk("rand", randomizer, 1'b0);
    chk("twoscomp", twoscomp, 1'b1);
    chk("sleep", sleep, 5'h05);
    chk("ilvds", ilvds, 3'b001);
    chk("termon", termon, 1'b1);
    chk("outoff", outoff, 1'b1);
    chk("outmode", outmode, 3'b011);
    chk("outtest", outtest, 1'b1);
    chk("testpattern", testpattern, 14'h127E);
    rd(7'd1); rd(7'd2); rd(7'd3); rd(7'd4);

    wr(7'd0, 8'h80);
    chk("swreset_fields", dut_fields, 31'h0);
    rd(7'd0);

    wr(7'd2, 8'h5A);
    s = act_strobes;
    exp_abort++;
    frame(1'b0, 7'd2, 8'hFF, 12, 0);
    chk("abort_count", act_abort, exp_abort);
    chk("abort_no_strobe", act_strobes, s);
    rd(7'd2);

    s = act_strobes;
    wr(7'd5, 8'h55);
    chk("bad_addr_no_strobe", act_strobes, s);
    rd(7'd5);
    chk("bad_addr_fields", dut_fields, model_fields());

    for (int n = 0; n < 24; n++) begin
      H = $urandom_range(4, 12);
      if ($urandom_range(0, 1) == 1) wr(7'($urandom_range(0, 7)), 8'($urandom));
      else rd(7'($urandom_range(0, 7)));
    end

    H = 8;
    wr(7'd2, 8'hC3);
    s = act_strobes;
    frame(1'b0, 7'd1, 8'hFF, 16, 10);
    chk("rst_frame_no_strobe", act_strobes, s);
    chk("rst_frame_no_abort", act_abort, exp_abort);
    wr(7'd1, 8'hFF);
    rd(7'd1);
    rd(7'd2);

    repeat (20) @(negedge clk);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    chk("abort_total", act_abort, exp_abort);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
